// File: rtl/instr_fetch_decode.sv
// RV32I front end: owns the PC, runs the imem req/ack handshake and presents
// raw instruction fields plus registered decode controls to the datapath.
module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_en_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] pc_out_o,
    output logic [6:0]  imm_B_MSB_o,
    output logic [4:0]  imm_B_LSB_o,
    output logic [11:0] imm_I_o,
    output logic [19:0] imm_J_o,
    output logic [6:0]  imm_S_MSB_o,
    output logic [4:0]  imm_S_LSB_o,
    output logic [19:0] imm_U_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rs1_o,
    output logic [3:0]  alu_ctrl_o,
    output logic        shamt_en_o,
    output logic [2:0]  branch_ctrl_o,
    output logic        jump_ctrl_o,
    output logic        reg_write_o,
    output logic [2:0]  inst_type_o
);
    typedef enum logic {FETCH, ISSUE} state_t;

    typedef struct packed {
        logic [3:0] alu;
        logic       shamt;
        logic [2:0] branch;
        logic       jump;
        logic       reg_write;
        logic [2:0] itype;
    } ctrl_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        kill_q, kill_d;
    logic [31:7] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d, dec;
    logic [31:0] redir_pc;
    logic [2:0]  f3;
    logic        f7b5;

    assign redir_pc = redirect_pc_i & ~32'd3;
    assign f3       = imem_rdata_i[14:12];
    assign f7b5     = imem_rdata_i[30];

    // Decode the incoming word so controls are registered alongside IR.
    always_comb begin
        dec = '0;
        case (imem_rdata_i[6:0])
            7'b0110011: begin
                dec.itype     = 3'b000;
                dec.alu       = {f7b5, f3};
                dec.reg_write = 1'b1;
            end
            7'b0010011: begin
                dec.itype     = 3'b001;
                dec.alu       = {(f3 == 3'b101) & f7b5, f3};
                dec.shamt     = (f3 == 3'b001) || (f3 == 3'b101);
                dec.reg_write = 1'b1;
            end
            7'b0000011: begin
                dec.itype     = 3'b001;
                dec.reg_write = 1'b1;
            end
            7'b1100111: begin
                dec.itype     = 3'b001;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            7'b0100011: dec.itype = 3'b010;
            7'b1100011: begin
                dec.itype  = 3'b011;
                dec.alu    = 4'b1000;
                dec.branch = f3;
            end
            7'b0110111, 7'b0010111: begin
                dec.itype     = 3'b100;
                dec.reg_write = 1'b1;
            end
            7'b1101111: begin
                dec.itype     = 3'b101;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: dec.itype = 3'b111;
        endcase
    end

    // Redirect wins over ack and stall. A redirect during an unacked fetch
    // parks the target in tgt_q so the bus address stays on the old request.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        kill_d   = kill_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;
        ctrl_d   = ctrl_q;
        case (state_q)
            FETCH: begin
                if (redirect_en_i) begin
                    if (imem_ack_i) begin
                        pc_d   = redir_pc;
                        kill_d = 1'b0;
                    end else begin
                        tgt_d  = redir_pc;
                        kill_d = 1'b1;
                    end
                end else if (imem_ack_i) begin
                    if (kill_q) begin
                        pc_d   = tgt_q;
                        kill_d = 1'b0;
                    end else begin
                        ir_d     = imem_rdata_i[31:7];
                        pc_out_d = pc_q;
                        ctrl_d   = dec;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (redirect_en_i) begin
                    pc_d    = redir_pc;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            tgt_q    <= RESET_PC;
            kill_q   <= 1'b0;
            ir_q     <= '0;
            pc_out_q <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            kill_q   <= kill_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
            ctrl_q   <= ctrl_d;
        end
    end

    // Request is masked by rst so memory never sees a fetch while in reset.
    assign imem_req_o    = (state_q == FETCH) && !rst_i;
    assign imem_addr_o   = pc_q;
    assign valid_o       = (state_q == ISSUE);
    assign pc_out_o      = pc_out_q;
    assign imm_I_o       = ir_q[31:20];
    assign imm_S_MSB_o   = ir_q[31:25];
    assign imm_B_MSB_o   = ir_q[31:25];
    assign imm_S_LSB_o   = ir_q[11:7];
    assign imm_B_LSB_o   = ir_q[11:7];
    assign imm_U_o       = ir_q[31:12];
    assign imm_J_o       = ir_q[31:12];
    assign rd_o          = ir_q[11:7];
    assign rs1_o         = ir_q[19:15];
    assign rs2_o         = ir_q[24:20];
    assign alu_ctrl_o    = ctrl_q.alu;
    assign shamt_en_o    = ctrl_q.shamt;
    assign branch_ctrl_o = ctrl_q.branch;
    assign jump_ctrl_o   = ctrl_q.jump;
    assign reg_write_o   = ctrl_q.reg_write;
    assign inst_type_o   = ctrl_q.itype;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: decode vector table, directed handshake
// sequences, and a randomized memory/stall/redirect run against a model.
module tb_instr_fetch_decode;
    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ack, redirect_en, stall, valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, pc_out;
    logic [6:0]  imm_B_MSB, imm_S_MSB;
    logic [4:0]  imm_B_LSB, imm_S_LSB, rd, rs2, rs1;
    logic [11:0] imm_I;
    logic [19:0] imm_J, imm_U;
    logic [3:0]  alu_ctrl;
    logic        shamt_en, jump_ctrl, reg_write;
    logic [2:0]  branch_ctrl, inst_type;

    always #5 clk = ~clk;

    instr_fetch_decode dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
        .redirect_en_i(redirect_en), .redirect_pc_i(redirect_pc),
        .stall_i(stall), .valid_o(valid), .pc_out_o(pc_out),
        .imm_B_MSB_o(imm_B_MSB), .imm_B_LSB_o(imm_B_LSB), .imm_I_o(imm_I),
        .imm_J_o(imm_J), .imm_S_MSB_o(imm_S_MSB), .imm_S_LSB_o(imm_S_LSB),
        .imm_U_o(imm_U), .rd_o(rd), .rs2_o(rs2), .rs1_o(rs1),
        .alu_ctrl_o(alu_ctrl), .shamt_en_o(shamt_en), .branch_ctrl_o(branch_ctrl),
        .jump_ctrl_o(jump_ctrl), .reg_write_o(reg_write), .inst_type_o(inst_type)
    );

    logic [135:0] outs;
    logic [12:0]  ctrl_out;
    assign ctrl_out = {alu_ctrl, shamt_en, branch_ctrl, jump_ctrl, reg_write, inst_type};
    assign outs = {pc_out, imm_B_MSB, imm_B_LSB, imm_I, imm_J, imm_S_MSB, imm_S_LSB,
                   imm_U, rd, rs2, rs1, ctrl_out};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Controls from the instruction-class rules: {alu, shamt, branch, jump, reg_write, type}.
    function automatic logic [12:0] ref_ctrl(input logic [31:0] w);
        string      k;
        logic [3:0] alu = '0;
        logic       sh = 1'b0;
        logic [2:0] br = '0;
        logic       j, rw;
        logic [2:0] t;
        case (w[6:0])
            7'h33:        k = "R";
            7'h13:        k = "IALU";
            7'h03:        k = "LOAD";
            7'h67:        k = "JALR";
            7'h23:        k = "S";
            7'h63:        k = "B";
            7'h37, 7'h17: k = "U";
            7'h6F:        k = "J";
            default:      k = "X";
        endcase
        t  = (k == "R") ? 3'd0 : (k == "IALU" || k == "LOAD" || k == "JALR") ? 3'd1 :
             (k == "S") ? 3'd2 : (k == "B") ? 3'd3 : (k == "U") ? 3'd4 :
             (k == "J") ? 3'd5 : 3'd7;
        rw = (t inside {3'd0, 3'd1, 3'd4, 3'd5});
        j  = (k == "J") || (k == "JALR");
        if (k == "R") alu = {w[30], w[14:12]};
        if (k == "IALU") begin
            alu = {(w[14:12] == 3'd5) && w[30], w[14:12]};
            sh  = (w[14:12] == 3'd1) || (w[14:12] == 3'd5);
        end
        if (k == "B") begin
            alu = 4'b1000;
            br  = w[14:12];
        end
        return {alu, sh, br, j, rw, t};
    endfunction

    function automatic logic [135:0] exp_outs(input logic [31:0] pc, input logic [31:0] w);
        return {pc, w[31:25], w[11:7], w[31:20], w[31:12], w[31:25], w[11:7], w[31:12],
                w[11:7], w[24:20], w[19:15], ref_ctrl(w)};
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_timeout", imem_req, 1);
    endtask

    typedef struct {
        logic [31:0] w;
        logic [2:0]  t;
        logic [3:0]  alu;
        logic        sh;
        logic [2:0]  br;
        logic        j;
        logic        rw;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];

    logic [31:0] rom[64];
    logic [6:0]  ops[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

    initial begin
        logic [135:0] snap;
        logic [31:0]  tmp;
        logic         m_valid, m_new, stale, fresh, p_req, p_ack;
        logic [31:0]  m_pc, m_word, nxt_pc, p_addr;
        logic [135:0] prev_outs;

        tbl[0]  = '{32'h002081B3, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[1]  = '{32'h40208133, 3'd0, 4'h8, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[2]  = '{32'h00500093, 3'd1, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[3]  = '{32'h40315093, 3'd1, 4'hD, 1'b1, 3'd0, 1'b0, 1'b1};
        tbl[4]  = '{32'h00311093, 3'd1, 4'h1, 1'b1, 3'd0, 1'b0, 1'b1};
        tbl[5]  = '{32'h4020C093, 3'd1, 4'h4, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[6]  = '{32'h0000A103, 3'd1, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[7]  = '{32'h000080E7, 3'd1, 4'h0, 1'b0, 3'd0, 1'b1, 1'b1};
        tbl[8]  = '{32'h0020A223, 3'd2, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{32'hFE208EE3, 3'd3, 4'h8, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{32'h00209463, 3'd3, 4'h8, 1'b0, 3'd1, 1'b0, 1'b0};
        tbl[11] = '{32'h12345537, 3'd4, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[12] = '{32'h00001517, 3'd4, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[13] = '{32'h008000EF, 3'd5, 4'h0, 1'b0, 3'd0, 1'b1, 1'b1};
        tbl[14] = '{32'h0000007F, 3'd7, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{32'hFFFFFFFF, 3'd7, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0};
        for (int i = 0; i < 64; i++) begin
            tmp    = $urandom;
            rom[i] = {tmp[31:7], ops[$urandom % 10]};
        end

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        redirect_en = 1'b0; redirect_pc = '0; stall = 1'b0;

        // Reset state
        step(); step();
        chk("rst_valid", valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_outs", outs, '0);
        chk("rst_addr", imem_addr, 0);
        rst = 1'b0; #1;
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, 0);

        // Zero-wait pair: add then addi
        imem_ack = 1'b1; imem_rdata = 32'h002081B3;
        step(); imem_ack = 1'b0;
        chk("add_valid", valid, 1);
        chk("add_type", inst_type, 0);
        chk("add_alu", alu_ctrl, 0);
        chk("add_regs", {rd, rs1, rs2}, {5'd3, 5'd1, 5'd2});
        chk("add_rw", reg_write, 1);
        chk("add_pc", pc_out, 0);
        chk("add_req", imem_req, 0);
        step();
        chk("gap_valid", valid, 0);
        chk("gap_req", imem_req, 1);
        chk("gap_addr", imem_addr, 4);
        imem_ack = 1'b1; imem_rdata = 32'h00500093;
        step(); imem_ack = 1'b0;
        chk("addi_valid", valid, 1);
        chk("addi_type", inst_type, 1);
        chk("addi_immI", imm_I, 5);
        chk("addi_pc", pc_out, 4);

        // Three stalled cycles hold everything
        snap = outs; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", valid, 1);
            chk("stall_outs", outs, snap);
            chk("stall_req", imem_req, 0);
        end
        stall = 1'b0;
        step();
        chk("after_stall_valid", valid, 0);
        chk("after_stall_addr", imem_addr, 8);

        // Redirect during a 3-cycle wait-state fetch of 0x8
        redirect_en = 1'b1; redirect_pc = 32'h103;
        step(); redirect_en = 1'b0;
        chk("kill_addr1", imem_addr, 8);
        chk("kill_req1", imem_req, 1);
        chk("kill_valid1", valid, 0);
        step();
        chk("kill_addr2", imem_addr, 8);
        imem_ack = 1'b1; imem_rdata = 32'h002081B3;
        step(); imem_ack = 1'b0;
        chk("kill_discard_valid", valid, 0);
        chk("kill_new_addr", imem_addr, 32'h100);
        imem_ack = 1'b1; imem_rdata = 32'h40315093;
        step(); imem_ack = 1'b0;
        chk("srai_valid", valid, 1);
        chk("srai_pc", pc_out, 32'h100);
        chk("srai_ctrl", {alu_ctrl, shamt_en}, {4'hD, 1'b1});

        // Redirect from ISSUE to the top word, then illegal opcode and wrap
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); redirect_en = 1'b0;
        chk("redir_issue_valid", valid, 0);
        chk("redir_issue_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h0000007F;
        step(); imem_ack = 1'b0;
        chk("ill_valid", valid, 1);
        chk("ill_type", inst_type, 7);
        chk("ill_ctrl", {alu_ctrl, shamt_en, branch_ctrl, jump_ctrl, reg_write}, 0);
        chk("ill_pc", pc_out, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr", imem_addr, 0);
        imem_ack = 1'b1; imem_rdata = 32'h00500093;
        step(); imem_ack = 1'b0;
        chk("pre_rst_valid", valid, 1);

        // Reset while in ISSUE, with a late ack during reset
        rst = 1'b1;
        step();
        chk("rst_issue_valid", valid, 0);
        chk("rst_issue_req", imem_req, 0);
        imem_ack = 1'b1; imem_rdata = 32'h002081B3;
        step();
        chk("rst_hold_valid", valid, 0);
        chk("rst_hold_outs", outs, '0);
        imem_ack = 1'b0; rst = 1'b0; #1;
        chk("rst_refetch_addr", imem_addr, 0);
        chk("rst_refetch_req", imem_req, 1);

        // Decode table, zero-wait, sequential PCs from 0
        for (int i = 0; i < NV; i++) begin
            wait_req();
            chk("dec_addr", imem_addr, 4 * i);
            imem_ack = 1'b1; imem_rdata = tbl[i].w;
            step(); imem_ack = 1'b0;
            chk("dec_valid", valid, 1);
            chk($sformatf("dec_ctrl_%08h", tbl[i].w), ctrl_out,
                {tbl[i].alu, tbl[i].sh, tbl[i].br, tbl[i].j, tbl[i].rw, tbl[i].t});
            chk("dec_fields", outs, exp_outs(32'(4 * i), tbl[i].w));
        end

        // Randomized run against a transaction-level model
        rst = 1'b1; step(); step(); rst = 1'b0; #1;
        m_valid = 1'b0; m_new = 1'b0; stale = 1'b0; nxt_pc = 0;
        m_pc = 0; m_word = 0; p_req = 1'b0; p_ack = 1'b0; p_addr = 0; prev_outs = '0;
        for (int r = 0; r < 3000; r++) begin
            chk("rnd_valid", valid, m_valid);
            if (m_new) chk("rnd_issue", outs, exp_outs(m_pc, m_word));
            else if (m_valid) chk("rnd_hold", outs, prev_outs);
            chk("rnd_req", imem_req, !m_valid);
            if (p_req && !p_ack) chk("rnd_addr_hold", imem_addr, p_addr);

            stall       = ($urandom % 3) == 0;
            redirect_en = ($urandom % 12) == 0;
            redirect_pc = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 + ($urandom % 8) : $urandom % 256;
            imem_ack    = imem_req && (($urandom % 2) == 0);
            imem_rdata  = imem_ack ? rom[imem_addr[7:2]] : $urandom;

            fresh = !m_valid && imem_ack && !redirect_en && !stale;
            if (fresh) chk("rnd_fetch_addr", imem_addr, nxt_pc);
            if (imem_ack) stale = 1'b0;
            else if (redirect_en && !m_valid) stale = 1'b1;
            if (redirect_en) nxt_pc = {redirect_pc[31:2], 2'b00};
            else if (m_valid && !stall) nxt_pc = m_pc + 32'd4;
            prev_outs = outs; p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            m_valid = fresh || (m_valid && stall && !redirect_en);
            m_new = fresh;
            if (fresh) begin
                m_pc = nxt_pc;
                m_word = imem_rdata;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Front-end stage that fetches 32-bit RV32I instructions from instruction memory and slices them into the raw immediate, register and control fields that the datapath consumes (`imm_*`, `rd`, `rs1`, `rs2`, `alu_ctrl`, `shamt_en`, `branch_ctrl`, `jump_ctrl`, `reg_write`, `inst_type`). It owns the PC and runs a req/ack handshake to memory. It holds each decoded instruction stable under a downstream stall and accepts PC redirects from branch/jump resolution.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ack  in  1  read data valid this cycle; may assert in the same cycle as imem_req
- imem_rdata  in  32  instruction word, sampled when imem_req&imem_ack
- redirect_en  in  1  taken branch/jump
- redirect_pc  in  32  target; bits [1:0] ignored (treated as 00)
- stall  in  1  downstream not ready; hold current instruction
- valid  out  1  decoded outputs hold a live instruction
- pc_out  out  32  PC of the instruction on the outputs
- imm_B_MSB 7, imm_B_LSB 5, imm_I 12, imm_J 20, imm_S_MSB 7, imm_S_LSB 5, imm_U 20, rd 5, rs2 5, rs1 5 (all out): raw instruction fields
- alu_ctrl  out  4; shamt_en  out  1; branch_ctrl  out  3; jump_ctrl  out  1; reg_write  out  1; inst_type  out  3

## Operation
- Field slicing (registered, from instruction register IR):
  - imm_I=IR[31:20]
  - imm_S_MSB=imm_B_MSB=IR[31:25]
  - imm_S_LSB=imm_B_LSB=IR[11:7]
  - imm_U=imm_J=IR[31:12]
  - rd=IR[11:7], rs1=IR[19:15], rs2=IR[24:20]
  - Fields are not reassembled or sign-extended here.
- inst_type by opcode: 0110011→000 (R); 0010011, 0000011, 1100111→001 (I); 0100011→010 (S); 1100011→011 (B); 0110111, 0010111→100 (U); 1101111→101 (J); any other opcode→111 (illegal).
- alu_ctrl:
  - R: {funct7[5], funct3}
  - I-ALU: {funct3==101 ? funct7[5] : 0, funct3}
  - B: 4'b1000
  - All other types: 4'b0000
- shamt_en=1 only for I-ALU with funct3 ∈ {001, 101}.
- branch_ctrl=funct3 for B, else 000.
- jump_ctrl=1 for JAL and JALR only.
- reg_write=1 for R, I, U, J; 0 for S, B, illegal.
- Illegal opcode: valid=1, inst_type=111, every other control output 0.
- FSM states:
  - FETCH: imem_req=1, imem_addr=PC.
    - On ack with kill=0: IR←rdata, pc_out←PC, go ISSUE.
    - On ack with kill=1: discard rdata, clear kill, stay in FETCH.
  - ISSUE: valid=1, outputs held.
    - stall=0: instruction consumed at the clock edge; PC←PC+4; go FETCH.
    - stall=1: remain in ISSUE, outputs unchanged.
- Redirect (priority over stall and ack):
  - PC←{redirect_pc[31:2], 2'b00}.
  - In ISSUE: valid=0 next cycle, go FETCH.
  - In FETCH with ack the same cycle: discard rdata, FETCH at target next cycle.
  - In FETCH without ack: set kill; imem_req/imem_addr remain held on the old address until ack, then that response is discarded.
  - A further redirect while kill is set overwrites the target.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- During rst, all outputs are 0 (valid=0, imem_req=0, all fields and controls 0); PC=RESET_PC, kill=0, state=FETCH.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- Ack in cycle N → valid=1 with decoded fields in cycle N+1.
- Minimum issue interval: 2 cycles per instruction (zero-wait memory, no stall).
- valid=0 in every FETCH cycle.
- rst mid-fetch or mid-issue: abandon immediately, drop imem_req the next cycle, discard any late ack.

## Test plan
- Zero-wait memory, instructions 0x002081B3 (add x3,x1,x2), then 0x00500093 (addi x1,x0,5):
  - first issue: inst_type=000, alu_ctrl=0000, rd=3, rs1=1, rs2=2, reg_write=1, pc_out=0
  - second issue: inst_type=001, imm_I=5, pc_out=4
  - valid pulses every 2nd cycle.
- Stall: stall=1 for 3 cycles during ISSUE → outputs and pc_out unchanged, imem_req=0; stall drops → next fetch at PC+4.
- Decode 0x40315093 (srai x1,x2,3) → alu_ctrl=1101, shamt_en=1. Decode 0xFE208EE3 (beq) → inst_type=011, branch_ctrl=000, alu_ctrl=1000, reg_write=0.
- Redirect to 0x103 during a 3-cycle wait-state fetch of 0x8 → imem_addr stays 0x8 until ack, that data is discarded, next fetch at 0x100, and no valid pulse for 0x8.
- Opcode 0x0000007F → valid=1, inst_type=111, all controls 0. Separately, PC=0xFFFFFFFC issues, then the next fetch is at 0x0.
- rst asserted while in ISSUE → valid=0 next cycle; the first post-reset fetch is at RESET_PC.
